// File: rtl/mem_pkg.sv
// Shared definitions for the 4-port time-sliced memory controller, its port
// masters and their benches.
package mem_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int NUM_PORTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SLOT = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_RESP      = 3'd4
  } mp_state_t;

endpackage

// File: rtl/mem_port_master.sv
// Initiator for one controller port: takes a single client request, waits for
// this port's slot, strobes the port once and returns the response.
module mem_port_master #(
  parameter int PORT_ID = 0,
  parameter int ADDR_W  = mem_pkg::ADDR_W,
  parameter int DATA_W  = mem_pkg::DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  input  logic [mem_pkg::SLOT_W-1:0] slot,
  output logic                       mem_en,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_input_data,
  input  logic [DATA_W-1:0]          mem_output_data
);
  import mem_pkg::*;

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0]  TMR_MAX  = '1;
  localparam logic [SLOT_W-1:0] MY_SLOT  = SLOT_W'(PORT_ID);

  mp_state_t         state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              op_wr_q, op_wr_d;
  logic              en_d, rd_d, wr_d, vld_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdat_d, rdata_d;
  logic              slot_hit;

  assign req_ready = (state_q == ST_IDLE);
  assign slot_hit  = (slot == MY_SLOT);

  // Next values for every register; strobes default low so they last one cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    op_wr_d = op_wr_q;
    en_d    = mem_en;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = mem_address;
    wdat_d  = mem_input_data;
    vld_d   = rsp_valid;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = ST_WAIT_SLOT;
          timer_d = '0;
          op_wr_d = req_write;
          addr_d  = req_addr;
          wdat_d  = req_wdata;
          en_d    = 1'b1;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_WAIT_SLOT: begin
        if (slot_hit) begin
          state_d = ST_ACCESS;
          rd_d    = !op_wr_q;
          wr_d    = op_wr_q;
        end else begin
          if (TIMEOUT != 0 && timer_q == TMR_LAST) begin
            state_d = ST_RESP;
            en_d    = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
          end
          if (timer_q != TMR_MAX) timer_d = timer_q + 1'b1;
        end
      end
      ST_ACCESS: begin
        // Slot moved away while strobing: the controller never saw it, retry.
        if (!slot_hit) begin
          state_d = ST_WAIT_SLOT;
        end else if (op_wr_q) begin
          state_d = ST_RESP;
          en_d    = 1'b0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        rdata_d = mem_output_data;
        state_d = ST_RESP;
        en_d    = 1'b0;
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end else begin
          vld_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      op_wr_q        <= 1'b0;
      mem_en         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_input_data <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      op_wr_q        <= op_wr_d;
      mem_en         <= en_d;
      mem_read       <= rd_d;
      mem_write      <= wr_d;
      mem_address    <= addr_d;
      mem_input_data <= wdat_d;
      rsp_valid      <= vld_d;
      rsp_rdata      <= rdata_d;
      rsp_err        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master: table of directed transactions, randomized
// transactions against a cycle-count model, and a reset-in-access sequence.
module tb_mem_port_master;
  import mem_pkg::*;

  localparam int PID = 2;
  localparam int TMO = 8;
  localparam int AW  = ADDR_W;
  localparam int DW  = DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0]     req_addr = '0;
  logic [DW-1:0]     req_wdata = '0, mem_output_data = '0;
  logic [SLOT_W-1:0] slot = '0;
  logic              req_ready, rsp_valid, rsp_err, mem_en, mem_read, mem_write;
  logic [DW-1:0]     rsp_rdata, mem_input_data;
  logic [AW-1:0]     mem_address;

  always #5 clk = ~clk;

  mem_port_master #(.PORT_ID(PID), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slot(slot), .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] od_q [64];   // controller read data offered in each cycle after accept

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] od;
    logic [63:0]   mask;      // bit n: slot equals PORT_ID during cycle n after accept
    int            rsp_cyc;
    bit            err;
    logic [DW-1:0] rdata;
    logic [63:0]   strb;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [SLOT_W-1:0] other_slot();
    int v;
    v = $urandom_range(0, NUM_PORTS - 2);
    if (v >= PID) v++;
    return v[SLOT_W-1:0];
  endfunction

  // Reference: walk the per-cycle slot matches. A matching waiting cycle is
  // followed by a strobe cycle; the strobe counts only if the slot still
  // matches. TMO non-matching waiting cycles abort with an error.
  function automatic void model(input bit wr, input logic [63:0] m, output int rc,
                                output bit err, output logic [DW-1:0] rd, output logic [63:0] strb);
    int n, miss;
    n = 0; miss = 0; rc = -1; err = 0; rd = '0; strb = '0;
    while (n < 58) begin
      if (m[n]) begin
        strb[n+1] = 1'b1;
        if (m[n+1]) begin
          if (wr) rc = n + 3;
          else begin rd = od_q[n+2]; rc = n + 4; end
          return;
        end
        n += 2;
      end else begin
        miss++;
        if (TMO != 0 && miss == TMO) begin err = 1; rc = n + 2; return; end
        n++;
      end
    end
  endfunction

  task automatic run_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [63:0] mask, input int bp,
                         input int e_rc, input bit e_err, input logic [DW-1:0] e_rd,
                         input logic [63:0] e_strb);
    logic [63:0]   s_rd, s_wr;
    logic [DW-1:0] rd_got;
    logic          err_got;
    int            rc;
    bit            bad_hold, bad_en, both, bad_stable;
    s_rd = '0; s_wr = '0; rc = -1; bad_hold = 0; bad_en = 0; both = 0; bad_stable = 0;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; slot = other_slot();
    @(posedge clk); #1;
    for (int n = 0; n < 62 && rc < 0; n++) begin
      slot = mask[n] ? SLOT_W'(PID) : other_slot();
      mem_output_data = od_q[n];
      // junk requests while busy must be ignored
      req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom_range(0, 1));
      req_addr = AW'($urandom); req_wdata = DW'($urandom);
      @(negedge clk);
      s_rd[n] = mem_read; s_wr[n] = mem_write;
      if (mem_read && mem_write) both = 1;
      if (mem_address !== addr || mem_input_data !== wdata || req_ready !== 1'b0) bad_hold = 1;
      if (rsp_valid === 1'b1) rc = n;
      else if (mem_en !== (n < e_rc - 1)) bad_en = 1;
      if (rc < 0) begin @(posedge clk); #1; end
    end
    req_valid = 1'b0;
    chk({tag, " rsp cycle"}, 64'(rc), 64'(e_rc));
    if (rc < 0) begin
      reset = 1'b1; @(negedge clk); reset = 1'b0;
      return;
    end
    chk({tag, " rd strobes"}, s_rd, wr ? 64'd0 : e_strb);
    chk({tag, " wr strobes"}, s_wr, wr ? e_strb : 64'd0);
    chk({tag, " rsp_err"}, 64'(rsp_err), 64'(e_err));
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(e_rd));
    chk({tag, " rd&wr"}, 64'(both), 64'd0);
    chk({tag, " addr/data hold"}, 64'(bad_hold), 64'd0);
    chk({tag, " mem_en"}, 64'(bad_en), 64'd0);
    rd_got = rsp_rdata; err_got = rsp_err;
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd_got || rsp_err !== err_got ||
          req_ready !== 1'b0 || mem_en !== 1'b0) bad_stable = 1;
    end
    chk({tag, " backpressure hold"}, 64'(bad_stable), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " rsp_valid drop"}, 64'(rsp_valid), 64'd0);
    chk({tag, " req_ready back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int            rc;
    bit            err, wr, bad;
    logic [DW-1:0] rd;
    logic [63:0]   strb, m;
    int            p;

    tbl[0] = '{1, 7'd10,   8'd10,   8'h00, ~64'h0,    3,  0, 8'h00, 64'h2};
    tbl[1] = '{0, 7'd10,   8'h00,   8'd10, ~64'h0,    4,  0, 8'd10, 64'h2};
    tbl[2] = '{1, 7'h55,   8'hA5,   8'h11, ~64'h1F,   8,  0, 8'h00, 64'h40};
    tbl[3] = '{0, 7'h33,   8'h00,   8'h5C, ~64'h2,    6,  0, 8'h5C, 64'hA};
    tbl[4] = '{0, 7'h01,   8'h00,   8'hFF, 64'h0,     9,  1, 8'h00, 64'h0};
    tbl[5] = '{1, 7'h7F,   8'hFF,   8'h00, ~64'h7F,   10, 0, 8'h00, 64'h100};
    tbl[6] = '{1, 7'h40,   8'h81,   8'h00, 64'h80,    11, 1, 8'h00, 64'h100};
    tbl[7] = '{0, 7'h2A,   8'h00,   8'h3C, ~64'h7F,   11, 0, 8'h3C, 64'h100};

    // reset state
    @(negedge clk); @(negedge clk);
    chk("reset mem_en", 64'(mem_en), 64'd0);
    chk("reset mem_read", 64'(mem_read), 64'd0);
    chk("reset mem_write", 64'(mem_write), 64'd0);
    chk("reset mem_address", 64'(mem_address), 64'd0);
    chk("reset mem_input_data", 64'(mem_input_data), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("reset rsp_err", 64'(rsp_err), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 64; c++) od_q[c] = tbl[i].od;
      run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mask,
              i % 4, tbl[i].rsp_cyc, tbl[i].err, tbl[i].rdata, tbl[i].strb);
    end

    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom_range(0, 1));
      p  = $urandom_range(1, 4);
      m  = '1;
      for (int b = 0; b < 24; b++) m[b] = ($urandom_range(0, 3) < p);
      for (int c = 0; c < 64; c++) od_q[c] = DW'($urandom);
      model(wr, m, rc, err, rd, strb);
      run_txn($sformatf("rnd%0d", t), wr, AW'($urandom), DW'($urandom), m,
              $urandom_range(0, 3), rc, err, rd, strb);
    end

    // reset between edges while the read strobe is up
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h21; slot = SLOT_W'(PID);
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2;
    chk("rst-access strobe up", 64'(mem_read), 64'd1);
    reset = 1'b1; #1;
    chk("rst-access mem_read", 64'(mem_read), 64'd0);
    chk("rst-access mem_write", 64'(mem_write), 64'd0);
    chk("rst-access mem_en", 64'(mem_en), 64'd0);
    chk("rst-access mem_address", 64'(mem_address), 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rst-access req_ready", 64'(req_ready), 64'd1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_read !== 1'b0) bad = 1;
    end
    chk("rst-access no response", 64'(bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
